// File: rtl/pit_table.sv
// Pending Interest Table: stores interests (prefix/len), buffers one data packet,
// matches it against every slot and forwards the hit (prefix, then payload bytes).

module pit_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic        clr,
  input  logic [63:0] wr_prefix,
  input  logic [5:0]  wr_len,
  input  logic [63:0] cmp_prefix,
  output logic        valid,
  output logic        hit,
  output logic        dup
);
  logic        valid_q, valid_d;
  logic [63:0] prefix_q, prefix_d;
  logic [5:0]  len_q, len_d;
  logic [63:0] mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      prefix_q <= '0;
      len_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      prefix_q <= prefix_d;
      len_q    <= len_d;
    end
  end

  always_comb begin
    valid_d  = valid_q;
    prefix_d = prefix_q;
    len_d    = len_q;
    if (wr) begin
      valid_d  = 1'b1;
      prefix_d = wr_prefix;
      len_d    = wr_len;
    end else if (clr) begin
      valid_d  = 1'b0;
    end
  end

  // len 0 compares the full 64 bits; otherwise only the top len bits
  assign mask  = (len_q == 6'd0) ? {64{1'b1}} : ~({64{1'b1}} >> len_q);
  assign valid = valid_q;
  assign hit   = valid_q && (((prefix_q ^ cmp_prefix) & mask) == 64'd0);
  assign dup   = valid_q && (prefix_q == wr_prefix) && (len_q == wr_len);
endmodule

module pit_table #(
  parameter int ENTRIES    = 4,
  parameter int DATA_BYTES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SPI_to_PIT_bit,
  input  logic [5:0]  SPI_to_PIT_length,
  input  logic [63:0] SPI_to_PIT_prefix,
  input  logic        data_start,
  input  logic [63:0] data_in_prefix,
  input  logic        data_in_valid,
  input  logic [7:0]  data_in_byte,
  output logic        data_in_ready,
  output logic        PIT_to_SPI_bit,
  output logic [63:0] PIT_to_SPI_prefix,
  output logic [7:0]  PIT_to_SPI_data,
  output logic [4:0]  pit_count,
  output logic        interest_drop,
  output logic        data_miss
);
  localparam int BW = DATA_BYTES * 8;
  localparam int CW = $clog2(DATA_BYTES);
  localparam logic [CW-1:0] LAST = CW'(DATA_BYTES - 1);

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_MATCH, S_ANNOUNCE, S_STREAM} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   pkt_prefix_q, pkt_prefix_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [63:0]   out_prefix_q, out_prefix_d;
  logic [7:0]    out_data_q, out_data_d;
  logic [4:0]    pit_count_q, pit_count_d;

  logic [ENTRIES-1:0] valid, hit, dup, clr, wr, free, valid_nx;
  logic               any_hit, agg;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_slot
    pit_slot u_slot (
      .clk        (clk),
      .rst        (rst),
      .wr         (wr[i]),
      .clr        (clr[i]),
      .wr_prefix  (SPI_to_PIT_prefix),
      .wr_len     (SPI_to_PIT_length),
      .cmp_prefix (pkt_prefix_q),
      .valid      (valid[i]),
      .hit        (hit[i]),
      .dup        (dup[i])
    );
  end

  // Free search sees pre-clear occupancy; a duplicate in a slot being cleared
  // does not absorb the interest, so the new interest always survives.
  assign any_hit  = |hit;
  assign clr      = (state_q == S_MATCH) ? hit : '0;
  assign free     = ~valid;
  assign agg      = |(dup & ~clr);
  assign wr       = (SPI_to_PIT_bit && !agg) ? (free & (~free + ENTRIES'(1))) : '0;
  assign valid_nx = (valid & ~clr) | wr;

  function automatic logic [4:0] popcnt(input logic [ENTRIES-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < ENTRIES; i++) c = c + 5'(v[i]);
    return c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pkt_prefix_q <= '0;
      buf_q        <= '0;
      out_prefix_q <= '0;
      out_data_q   <= '0;
      pit_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pkt_prefix_q <= pkt_prefix_d;
      buf_q        <= buf_d;
      out_prefix_q <= out_prefix_d;
      out_data_q   <= out_data_d;
      pit_count_q  <= pit_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pkt_prefix_d = pkt_prefix_q;
    buf_d        = buf_q;
    out_prefix_d = out_prefix_q;
    out_data_d   = out_data_q;
    pit_count_d  = popcnt(valid_nx);
    case (state_q)
      S_IDLE: if (data_start) begin
        state_d      = S_RECV;
        pkt_prefix_d = data_in_prefix;
        cnt_d        = '0;
      end
      S_RECV: if (data_in_valid) begin
        buf_d = {buf_q[BW-9:0], data_in_byte};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = S_MATCH;
      end
      S_MATCH: if (any_hit) begin
        state_d      = S_ANNOUNCE;
        out_prefix_d = pkt_prefix_q;
      end else begin
        state_d = S_IDLE;
      end
      S_ANNOUNCE: begin
        state_d    = S_STREAM;
        cnt_d      = '0;
        out_data_d = buf_q[BW-1 -: 8];
        buf_d      = {buf_q[BW-9:0], 8'h00};
      end
      S_STREAM: if (cnt_q == LAST) begin
        state_d = S_IDLE;
      end else begin
        cnt_d      = cnt_q + CW'(1);
        out_data_d = buf_q[BW-1 -: 8];
        buf_d      = {buf_q[BW-9:0], 8'h00};
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign data_in_ready     = (state_q == S_IDLE) || (state_q == S_RECV);
  assign PIT_to_SPI_bit    = (state_q == S_ANNOUNCE);
  assign PIT_to_SPI_prefix = out_prefix_q;
  assign PIT_to_SPI_data   = out_data_q;
  assign pit_count         = pit_count_q;
  assign interest_drop     = SPI_to_PIT_bit && !agg && !(|free);
  assign data_miss         = (state_q == S_MATCH) && !any_hit;
endmodule

// File: tb/tb_pit_table.sv
// Directed bench for pit_table: payload bytes queued on send, popped as they stream out.

module tb_pit_table;
  localparam int DB = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        SPI_to_PIT_bit;
  logic [5:0]  SPI_to_PIT_length;
  logic [63:0] SPI_to_PIT_prefix;
  logic        data_start;
  logic [63:0] data_in_prefix;
  logic        data_in_valid;
  logic [7:0]  data_in_byte;
  logic        data_in_ready;
  logic        PIT_to_SPI_bit;
  logic [63:0] PIT_to_SPI_prefix;
  logic [7:0]  PIT_to_SPI_data;
  logic [4:0]  pit_count;
  logic        interest_drop;
  logic        data_miss;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  pit_table #(.ENTRIES(4), .DATA_BYTES(DB)) dut (
    .clk               (clk),
    .rst               (rst),
    .SPI_to_PIT_bit    (SPI_to_PIT_bit),
    .SPI_to_PIT_length (SPI_to_PIT_length),
    .SPI_to_PIT_prefix (SPI_to_PIT_prefix),
    .data_start        (data_start),
    .data_in_prefix    (data_in_prefix),
    .data_in_valid     (data_in_valid),
    .data_in_byte      (data_in_byte),
    .data_in_ready     (data_in_ready),
    .PIT_to_SPI_bit    (PIT_to_SPI_bit),
    .PIT_to_SPI_prefix (PIT_to_SPI_prefix),
    .PIT_to_SPI_data   (PIT_to_SPI_data),
    .pit_count         (pit_count),
    .interest_drop     (interest_drop),
    .data_miss         (data_miss)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic insert(input logic [63:0] p, input logic [5:0] len,
                        input logic exp_drop, input logic [4:0] exp_cnt);
    SPI_to_PIT_bit    = 1'b1;
    SPI_to_PIT_prefix = p;
    SPI_to_PIT_length = len;
    @(negedge clk);
    check("interest_drop", interest_drop, exp_drop);
    tick();
    SPI_to_PIT_bit = 1'b0;
    check("pit_count_ins", pit_count, exp_cnt);
  endtask

  // Sends one packet; optionally gaps the byte stream and/or inserts an interest in the MATCH cycle.
  task automatic send_pkt(input logic [63:0] p, input logic [7:0] base, input logic hit,
                          input logic gaps, input logic [4:0] exp_cnt,
                          input logic ins, input logic [63:0] ip, input logic [5:0] il);
    logic [7:0] last;
    last = 8'h00;
    @(negedge clk);
    check("ready_idle", data_in_ready, 1'b1);
    data_start     = 1'b1;
    data_in_prefix = p;
    tick();
    data_start = 1'b0;
    for (int k = 0; k < DB; k++) begin
      if (gaps && (k % 5 == 2)) begin
        data_in_valid = 1'b0;
        tick();
      end
      data_in_valid = 1'b1;
      data_in_byte  = base + 8'(k);
      if (hit) exp_q.push_back(base + 8'(k));
      tick();
    end
    data_in_valid = 1'b0;
    if (ins) begin
      SPI_to_PIT_bit    = 1'b1;
      SPI_to_PIT_prefix = ip;
      SPI_to_PIT_length = il;
    end
    @(negedge clk);
    check("ready_match", data_in_ready, 1'b0);
    check("data_miss", data_miss, !hit);
    check("announce_early", PIT_to_SPI_bit, 1'b0);
    if (ins) check("drop_at_match", interest_drop, 1'b0);
    tick();
    SPI_to_PIT_bit = 1'b0;
    @(negedge clk);
    check("pit_count_after", pit_count, exp_cnt);
    if (hit) begin
      check("announce", PIT_to_SPI_bit, 1'b1);
      check("announce_prefix", PIT_to_SPI_prefix, p);
      check("miss_on_hit", data_miss, 1'b0);
      for (int k = 0; k < DB; k++) begin
        tick();
        if (k == 5) begin
          data_start     = 1'b1;
          data_in_prefix = 64'hDEAD_BEEF_0000_0000;
        end
        @(negedge clk);
        if (exp_q.size() == 0) begin
          check("stream_queue_empty", 1'b1, 1'b0);
        end else begin
          last = exp_q.pop_front();
          check("stream_byte", PIT_to_SPI_data, last);
        end
        if (k == 0 || k == DB - 1) check("ready_stream", data_in_ready, 1'b0);
        if (k == 1 || k == DB - 1) check("announce_stream", PIT_to_SPI_bit, 1'b0);
        data_start = 1'b0;
      end
      tick();
      @(negedge clk);
      check("data_hold", PIT_to_SPI_data, last);
      check("prefix_hold", PIT_to_SPI_prefix, p);
    end else begin
      check("no_announce", PIT_to_SPI_bit, 1'b0);
    end
    check("ready_after", data_in_ready, 1'b1);
    check("announce_after", PIT_to_SPI_bit, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    SPI_to_PIT_bit = 1'b0; SPI_to_PIT_length = '0; SPI_to_PIT_prefix = '0;
    data_start = 1'b0; data_in_prefix = '0; data_in_valid = 1'b0; data_in_byte = '0;
    tick(); tick();
    @(negedge clk);
    check("rst_ready", data_in_ready, 1'b1);
    check("rst_bit", PIT_to_SPI_bit, 1'b0);
    check("rst_prefix", PIT_to_SPI_prefix, 64'd0);
    check("rst_data", PIT_to_SPI_data, 8'd0);
    check("rst_count", pit_count, 5'd0);
    check("rst_drop", interest_drop, 1'b0);
    check("rst_miss", data_miss, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // single len-16 interest, hit
    insert(64'hAABB_CCDD_0000_0000, 6'd16, 1'b0, 5'd1);
    send_pkt(64'hAABB_1234_5678_9ABC, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 64'd0, 6'd0);

    // empty table miss
    send_pkt(64'h1111_0000_0000_0000, 8'h40, 1'b0, 1'b0, 5'd0, 1'b0, 64'd0, 6'd0);

    // fill table, drop 5th, aggregate duplicate, then one packet clears all four
    insert(64'h5000_0000_0000_0000, 6'd4, 1'b0, 5'd1);
    insert(64'h5100_0000_0000_0000, 6'd4, 1'b0, 5'd2);
    insert(64'h5200_0000_0000_0000, 6'd4, 1'b0, 5'd3);
    insert(64'h5300_0000_0000_0000, 6'd4, 1'b0, 5'd4);
    insert(64'h5400_0000_0000_0000, 6'd4, 1'b1, 5'd4);
    insert(64'h5000_0000_0000_0000, 6'd4, 1'b0, 5'd4);
    send_pkt(64'h5FFF_0000_0000_0000, 8'h80, 1'b1, 1'b1, 5'd0, 1'b0, 64'd0, 6'd0);

    // len 8 and len 0 both hit; a len-0 entry one LSB off must survive
    insert(64'hAB00_0000_0000_0000, 6'd8, 1'b0, 5'd1);
    insert(64'hABCD_EF01_2345_6789, 6'd0, 1'b0, 5'd2);
    insert(64'hABCD_EF01_2345_6788, 6'd0, 1'b0, 5'd3);
    send_pkt(64'hABCD_EF01_2345_6789, 8'hA0, 1'b1, 1'b0, 5'd1, 1'b0, 64'd0, 6'd0);

    // insert during MATCH that clears slot 0; the new, also-matching interest survives
    insert(64'h7700_0000_0000_0000, 6'd8, 1'b0, 5'd2);
    send_pkt(64'h7700_1234_0000_0000, 8'hC0, 1'b1, 1'b0, 5'd2, 1'b1, 64'h7700_0000_0000_0000, 6'd16);
    send_pkt(64'h7700_1234_0000_0000, 8'h10, 1'b1, 1'b0, 5'd1, 1'b0, 64'd0, 6'd0);

    // reset at byte 10 aborts a packet that would have hit the remaining entry
    data_start     = 1'b1;
    data_in_prefix = 64'hABCD_EF01_2345_6788;
    tick();
    data_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      data_in_valid = 1'b1;
      data_in_byte  = 8'(k);
      tick();
    end
    data_in_byte = 8'd10;
    rst = 1'b1;
    #2;
    check("abort_ready", data_in_ready, 1'b1);
    check("abort_count", pit_count, 5'd0);
    check("abort_bit", PIT_to_SPI_bit, 1'b0);
    data_in_valid = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_no_announce", PIT_to_SPI_bit, 1'b0);
      tick();
    end
    send_pkt(64'hABCD_EF01_2345_6788, 8'h20, 1'b0, 1'b0, 5'd0, 1'b0, 64'd0, 6'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
